// File: rtl/mem_wb_elastic_pkg.sv
// Shared constants and small helpers for the elastic MEM/WB stage.
package mem_wb_elastic_pkg;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;

  localparam int CH_GPR  = 0;
  localparam int CH_HILO = 1;

  // The out slot can take a new entry when it is empty or is draining this cycle.
  function automatic logic out_slot_free(input logic out_valid, input logic out_fire);
    return (!out_valid) || out_fire;
  endfunction

endpackage

// File: rtl/mem_wb_elastic_if.sv
// Valid/ready write-back bus: per-channel dest address, write enable and data.
interface mem_wb_elastic_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2
) ();

  logic                     valid;
  logic                     ready;
  logic [NUM_CH*ADDR_W-1:0] wd;
  logic [NUM_CH-1:0]        wreg;
  logic [NUM_CH*DATA_W-1:0] wdata;

  modport master (output valid, output wd, output wreg, output wdata, input ready);
  modport slave  (input valid, input wd, input wreg, input wdata, output ready);

endinterface

// File: rtl/mem_wb_elastic_wb_entry_reg.sv
// One write-back entry (all channels) with load enable and clear.
module wb_entry_reg
  import mem_wb_elastic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     clear,
  input  logic [NUM_CH*ADDR_W-1:0] d_wd,
  input  logic [NUM_CH-1:0]        d_wreg,
  input  logic [NUM_CH*DATA_W-1:0] d_wdata,
  output logic [NUM_CH*ADDR_W-1:0] q_wd,
  output logic [NUM_CH-1:0]        q_wreg,
  output logic [NUM_CH*DATA_W-1:0] q_wdata
);

  // Entry storage; clear dominates load so a flushed slot never keeps stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_wd    <= '0;
      q_wreg  <= {NUM_CH{WriteDisable}};
      q_wdata <= '0;
    end else if (clear) begin
      q_wd    <= '0;
      q_wreg  <= {NUM_CH{WriteDisable}};
      q_wdata <= '0;
    end else if (load) begin
      q_wd    <= d_wd;
      q_wreg  <= d_wreg;
      q_wdata <= d_wdata;
    end
  end

endmodule

// File: rtl/mem_wb_elastic.sv
// Elastic MEM/WB stage: out register plus one skid entry, flush, bubble counter.
module mem_wb_elastic
  import mem_wb_elastic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_mem,
  input  logic                  stall_wb,
  input  logic                  flush,
  mem_wb_elastic_if.slave       mem,
  mem_wb_elastic_if.master      wb,
  output logic [CNT_W-1:0]      bubble_cnt
);

  logic out_valid_r, skid_valid_r, mem_ready_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  logic acc_s, fire_s;
  logic out_valid_nxt_s, skid_valid_nxt_s;
  logic out_load_s, out_clear_s, out_from_skid_s;
  logic skid_load_s, skid_clear_s;

  logic [NUM_CH*ADDR_W-1:0] out_q_wd, skid_q_wd, out_d_wd;
  logic [NUM_CH-1:0]        out_q_wreg, skid_q_wreg, out_d_wreg;
  logic [NUM_CH*DATA_W-1:0] out_q_wdata, skid_q_wdata, out_d_wdata;

  // Slot routing: flush first, then skid->out promotion, then new entry placement.
  always_comb begin
    acc_s            = mem.valid & mem_ready_r & (stall_mem == NoStop) & ~flush;
    fire_s           = out_valid_r & wb.ready & (stall_wb == NoStop);
    out_valid_nxt_s  = out_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    out_load_s       = 1'b0;
    out_clear_s      = 1'b0;
    out_from_skid_s  = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (flush) begin
      out_valid_nxt_s  = 1'b0;
      skid_valid_nxt_s = 1'b0;
      out_clear_s      = 1'b1;
      skid_clear_s     = 1'b1;
    end else if (fire_s && skid_valid_r) begin
      out_load_s       = 1'b1;
      out_from_skid_s  = 1'b1;
      skid_valid_nxt_s = acc_s;
      skid_load_s      = acc_s;
      skid_clear_s     = ~acc_s;
    end else if (acc_s && out_slot_free(out_valid_r, fire_s) && !skid_valid_r) begin
      out_load_s       = 1'b1;
      out_valid_nxt_s  = 1'b1;
    end else if (acc_s) begin
      skid_load_s      = 1'b1;
      skid_valid_nxt_s = 1'b1;
    end else if (fire_s) begin
      out_valid_nxt_s  = 1'b0;
      out_clear_s      = 1'b1;
    end else begin
      out_valid_nxt_s  = out_valid_r;
    end
  end

  assign out_d_wd    = out_from_skid_s ? skid_q_wd    : mem.wd;
  assign out_d_wreg  = out_from_skid_s ? skid_q_wreg  : mem.wreg;
  assign out_d_wdata = out_from_skid_s ? skid_q_wdata : mem.wdata;

  wb_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) u_out (
    .clk(clk), .rst(rst), .load(out_load_s), .clear(out_clear_s),
    .d_wd(out_d_wd), .d_wreg(out_d_wreg), .d_wdata(out_d_wdata),
    .q_wd(out_q_wd), .q_wreg(out_q_wreg), .q_wdata(out_q_wdata)
  );

  wb_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) u_skid (
    .clk(clk), .rst(rst), .load(skid_load_s), .clear(skid_clear_s),
    .d_wd(mem.wd), .d_wreg(mem.wreg), .d_wdata(mem.wdata),
    .q_wd(skid_q_wd), .q_wreg(skid_q_wreg), .q_wdata(skid_q_wdata)
  );

  // Valid bits, registered ready and the saturating bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      mem_ready_r  <= 1'b1;
      bubble_cnt_r <= '0;
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      mem_ready_r  <= ~skid_valid_nxt_s;
      if (!out_valid_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
      end
    end
  end

  assign mem.ready  = mem_ready_r;
  assign wb.valid   = out_valid_r;
  assign wb.wreg    = out_q_wreg & {NUM_CH{out_valid_r}};
  assign wb.wd      = out_valid_r ? out_q_wd : '0;
  assign wb.wdata   = out_valid_r ? out_q_wdata : '0;
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Bench for mem_wb_elastic: directed scenarios plus random traffic against a queue model.
module tb_mem_wb_elastic;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NC  = 2;
  localparam int CW  = 16;
  localparam int CWS = 4;

  typedef struct packed {
    logic [NC*AW-1:0] wd;
    logic [NC-1:0]    wreg;
    logic [NC*DW-1:0] wdata;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_mem = 1'b0;
  logic stall_wb = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0]  bubble_cnt;
  logic [CWS-1:0] sat_bubble_cnt;

  mem_wb_elastic_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) mem_if ();
  mem_wb_elastic_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) wb_if ();
  mem_wb_elastic_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) sat_mem_if ();
  mem_wb_elastic_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) sat_wb_if ();

  always #5 clk = ~clk;

  mem_wb_elastic #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem(mem_if), .wb(wb_if), .bubble_cnt(bubble_cnt)
  );

  // Always-idle instance with a narrow counter for saturation.
  mem_wb_elastic #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .CNT_W(CWS)) dut_sat (
    .clk(clk), .rst(rst), .stall_mem(1'b0), .stall_wb(1'b0), .flush(1'b0),
    .mem(sat_mem_if), .wb(sat_wb_if), .bubble_cnt(sat_bubble_cnt)
  );

  ent_t q[$];
  int unsigned bub;
  int unsigned sat_bub;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v);
    logic [31:0] r0, r1, r2, r3;
    r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    mem_if.valid = v;
    mem_if.wd    = r0[NC*AW-1:0];
    mem_if.wreg  = r1[NC-1:0];
    mem_if.wdata = {r2, r3};
  endtask

  task automatic check_outputs();
    ent_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    chk("wb_valid",   64'(wb_if.valid), 64'(q.size() > 0));
    chk("wb_wreg",    64'(wb_if.wreg),  64'(e.wreg));
    chk("wb_wd",      64'(wb_if.wd),    64'(e.wd));
    chk("wb_wdata",   64'(wb_if.wdata), 64'(e.wdata));
    chk("mem_ready",  64'(mem_if.ready), 64'(q.size() < 2));
    chk("bubble_cnt", 64'(bubble_cnt),  64'(bub));
    chk("sat_bubble", 64'(sat_bubble_cnt), 64'(sat_bub));
  endtask

  // Advance one clock: update the FIFO model from the current inputs, then compare.
  task automatic step();
    ent_t cur;
    bit acc_m, fire_m, empty_m;
    cur = {mem_if.wd, mem_if.wreg, mem_if.wdata};
    if (rst) begin
      q.delete();
      bub = 0;
      sat_bub = 0;
    end else begin
      empty_m = (q.size() == 0);
      acc_m   = mem_if.valid && (q.size() < 2) && !stall_mem && !flush;
      fire_m  = (q.size() > 0) && wb_if.ready && !stall_wb;
      if (flush) begin
        q.delete();
      end else begin
        if (fire_m) void'(q.pop_front());
        if (acc_m) q.push_back(cur);
      end
      if (empty_m && bub < (2**CW - 1)) bub++;
      if (sat_bub < (2**CWS - 1)) sat_bub++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int unsigned b0;
    sat_mem_if.valid = 1'b0;
    sat_mem_if.wd    = '0;
    sat_mem_if.wreg  = '0;
    sat_mem_if.wdata = '0;
    sat_wb_if.ready  = 1'b1;
    wb_if.ready      = 1'b1;
    drive(1'b0);
    bub = 0;
    sat_bub = 0;

    // Reset state
    step();
    step();
    rst = 1'b0;

    // 1: stream 4 entries, no back-pressure
    for (int i = 0; i < 4; i++) begin
      drive(1'b1);
      step();
    end
    drive(1'b0);
    step();
    step();

    // 2: back-pressure fills out and skid, then releases in order
    wb_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1);
      step();
    end
    wb_if.ready = 1'b1;
    drive(1'b0);
    for (int i = 0; i < 3; i++) step();

    // 3: stall_mem with out occupied drains and then inserts bubbles
    drive(1'b1);
    step();
    b0 = 32'(bubble_cnt);
    stall_mem = 1'b1;
    step();
    step();
    stall_mem = 1'b0;
    drive(1'b0);
    step();
    chk("t3_bubble_delta", 64'(32'(bubble_cnt) - b0), 64'd2);

    // 4: flush with both slots full drops everything including the new input
    wb_if.ready = 1'b0;
    drive(1'b1);
    step();
    drive(1'b1);
    step();
    chk("t4_full", 64'(mem_if.ready), 64'd0);
    flush = 1'b1;
    drive(1'b1);
    step();
    flush = 1'b0;
    drive(1'b0);
    wb_if.ready = 1'b1;
    chk("t4_ready_after_flush", 64'(mem_if.ready), 64'd1);
    chk("t4_no_wreg", 64'(wb_if.wreg), 64'd0);
    step();

    // 5: asynchronous reset mid-cycle while both write enables are up
    drive(1'b1);
    mem_if.wreg = 2'b11;
    step();
    chk("t5_wreg_before", 64'(wb_if.wreg), 64'd3);
    drive(1'b0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    bub = 0;
    sat_bub = 0;
    chk("t5_async_valid", 64'(wb_if.valid), 64'd0);
    chk("t5_async_wreg",  64'(wb_if.wreg),  64'd0);
    chk("t5_async_wdata", 64'(wb_if.wdata), 64'd0);
    chk("t5_async_bub",   64'(bubble_cnt),  64'd0);
    step();
    rst = 1'b0;
    chk("t5_ready_after_rst", 64'(mem_if.ready), 64'd1);

    // 6: narrow counter saturates after 20 idle cycles
    for (int i = 0; i < 20; i++) step();
    chk("t6_saturated", 64'(sat_bubble_cnt), 64'hF);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0);
      wb_if.ready = ($urandom % 3) != 0;
      stall_mem   = ($urandom % 8) == 0;
      stall_wb    = ($urandom % 8) == 0;
      flush       = ($urandom % 32) == 0;
      step();
    end
    drive(1'b0);
    wb_if.ready = 1'b1;
    stall_mem = 1'b0;
    stall_wb = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
